// File: rtl/dpram_pkg.sv
// Shared types and constants for the two-port arbiter in front of the single-port RAM.
// Build option: define DPRAM_ARB_RR_EN for round-robin contests (default is fixed priority, A wins).
package dpram_pkg;

  typedef logic port_id_t;

  localparam port_id_t    PORT_A     = 1'b0;
  localparam port_id_t    PORT_B     = 1'b1;
  localparam int unsigned RD_LAT_MAX = 4;

`ifdef DPRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

  // Winner of a simultaneous A/B request: 1 means B is granted.
  function automatic logic contest_to_b(input port_id_t last_gnt);
    return RR_EN && (last_gnt == PORT_A);
  endfunction

endpackage

// File: rtl/dpram_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, port} of each issued read alongside the RAM read latency.
module dpram_rd_tag_pipe
  import dpram_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  // Out-of-range latencies are clamped to the supported 1..RD_LAT_MAX window.
  localparam int unsigned DEPTH = (RD_LAT < 1) ? 1 :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  rd_tag_t pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-client front end for a single-port RAM: one access per cycle, read data routed back to its issuer.
// Build option: DPRAM_ARB_RR_EN selects round-robin contests; otherwise port A has fixed priority.
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  port_id_t last_gnt;
  rd_tag_t  tag_in;
  rd_tag_t  tag_out;

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        b_gnt = contest_to_b(last_gnt);
        a_gnt = ~b_gnt;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (a_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (a_gnt & ~a_we) | (b_gnt & ~b_we);
    tag_in.port  = b_gnt ? PORT_B : PORT_A;
  end

  // Idle cycles leave the last winner untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT_B;
    end else if (a_gnt) begin
      last_gnt <= PORT_A;
    end else if (b_gnt) begin
      last_gnt <= PORT_B;
    end
  end

  dpram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_out.valid && (tag_out.port == PORT_A);
      b_rvalid <= tag_out.valid && (tag_out.port == PORT_B);
      if (tag_out.valid && (tag_out.port == PORT_A)) a_rdata <= ram_rdata;
      if (tag_out.valid && (tag_out.port == PORT_B)) b_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: directed scenarios plus randomized clients vs a transaction-level model.
module tb_dpram_port_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

`ifdef DPRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              ram_ce, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM stand-in; unread cycles return garbage so misaligned captures show up.
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] rd_sr [RD_LAT];

  always @(posedge clk) begin
    if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
    rd_sr[0] <= (ram_ce && !ram_we) ? mem[ram_addr] : DATA_W'($urandom);
    for (int i = 1; i < int'(RD_LAT); i++) rd_sr[i] <= rd_sr[i-1];
  end
  assign ram_rdata = rd_sr[RD_LAT-1];

  // Reference model state
  typedef struct {
    bit                port;
    logic [DATA_W-1:0] data;
    int                due;
  } ret_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  ret_t              ret_q [$];
  bit                model_last;
  logic [DATA_W-1:0] exp_a_rdata, exp_b_rdata;
  logic              obs_a_gnt, obs_b_gnt;
  int                cyc;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input int addr, input int wd);
    a_req = req; a_we = we; a_addr = ADDR_W'(addr); a_wdata = DATA_W'(wd);
  endtask

  task automatic drive_b(input logic req, input logic we, input int addr, input int wd);
    b_req = req; b_we = we; b_addr = ADDR_W'(addr); b_wdata = DATA_W'(wd);
  endtask

  // One clock: check DUT against the model at negedge, advance the model, step to posedge+1.
  task automatic run_cycle(output bit ga, output bit gb);
    bit                win_b, exp_arv, exp_brv, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    ret_t              r;
    @(negedge clk);
    if (a_req && b_req) begin
      win_b = RR ? (model_last == 1'b0) : 1'b0;
      ga = !win_b;
      gb = win_b;
    end else begin
      ga = a_req;
      gb = b_req;
    end
    obs_a_gnt = a_gnt;
    obs_b_gnt = b_gnt;
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("ram_ce", ram_ce, ga | gb);
    we = gb ? b_we : a_we;
    addr = gb ? b_addr : a_addr;
    wd = gb ? b_wdata : a_wdata;
    if (ga || gb) begin
      chk("ram_we", ram_we, we);
      chk("ram_addr", ram_addr, addr);
      if (we) chk("ram_wdata", ram_wdata, wd);
    end else begin
      chk("ram_we_idle", ram_we, 0);
    end
    exp_arv = 1'b0;
    exp_brv = 1'b0;
    if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.port) begin exp_brv = 1'b1; exp_b_rdata = r.data; end
      else        begin exp_arv = 1'b1; exp_a_rdata = r.data; end
    end
    chk("a_rvalid", a_rvalid, exp_arv);
    chk("b_rvalid", b_rvalid, exp_brv);
    chk("a_rdata", a_rdata, exp_a_rdata);
    chk("b_rdata", b_rdata, exp_b_rdata);
    if (ga || gb) begin
      model_last = gb;
      if (we) begin
        ref_mem[addr] = wd;
      end else begin
        r.port = gb;
        r.data = ref_mem[addr];
        r.due  = cyc + int'(RD_LAT) + 1;
        ret_q.push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    for (int i = 0; i < n; i++) run_cycle(ga, gb);
  endtask

  task automatic model_reset();
    ret_q.delete();
    model_last  = 1'b1;
    exp_a_rdata = '0;
    exp_b_rdata = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, gb;
    bit pa, pb, awe, bwe;
    int aad, bad, awd, bwd;

    cyc = 0;
    model_reset();
    drive_a(1, 0, 0, 0);
    drive_b(1, 0, 0, 0);
    rst_n = 1'b0;
    #3;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_ram_ce", ram_ce, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rdata", b_rdata, 0);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preload every RAM word, alternating the single active port.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i % 2 == 0) begin drive_a(1, 1, i, $urandom); drive_b(0, 0, 0, 0); end
      else            begin drive_b(1, 1, i, $urandom); drive_a(0, 0, 0, 0); end
      run_cycle(ga, gb);
    end

    // Lone A write then read of address 5.
    drive_b(0, 0, 0, 0);
    drive_a(1, 1, 5, 8'hA5); run_cycle(ga, gb);
    drive_a(1, 0, 5, 0);     run_cycle(ga, gb);
    chk("t1_a_gnt", obs_a_gnt, 1);
    idle(int'(RD_LAT) + 1);
    chk("t1_a_rdata", a_rdata, 8'hA5);

    // Lone B write leaves B as last winner, then four cycles of contention.
    drive_b(1, 1, 20, 8'h11); run_cycle(ga, gb);
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 0, 30 + i, 0);
      drive_b(1, 0, 40 + i, 0);
      run_cycle(ga, gb);
      chk("t2_a_gnt", obs_a_gnt, RR ? ((i % 2) == 0) : 1'b1);
      chk("t2_b_gnt", obs_b_gnt, RR ? ((i % 2) == 1) : 1'b0);
    end

    // Contest, idle gap, contest: the gap must not disturb the rotation.
    drive_a(1, 0, 1, 0); drive_b(1, 0, 2, 0); run_cycle(ga, gb);
    chk("t6_first_a", obs_a_gnt, 1);
    idle(1);
    drive_a(1, 0, 3, 0); drive_b(1, 0, 4, 0); run_cycle(ga, gb);
    chk("t6_second_b", obs_b_gnt, RR);
    idle(int'(RD_LAT) + 1);

    // A write followed immediately by a B read of the same address.
    drive_a(1, 1, 7, 8'h3C); run_cycle(ga, gb);
    drive_a(0, 0, 0, 0); drive_b(1, 0, 7, 0); run_cycle(ga, gb);
    idle(int'(RD_LAT) + 1);
    chk("t3_b_rdata", b_rdata, 8'h3C);

    // Alternating single-port reads every cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin drive_a(1, 0, $urandom_range(63), 0); drive_b(0, 0, 0, 0); end
      else            begin drive_b(1, 0, $urandom_range(63), 0); drive_a(0, 0, 0, 0); end
      run_cycle(ga, gb);
    end
    idle(int'(RD_LAT) + 1);

    // Reset while a read is in flight.
    drive_a(1, 0, 9, 0); run_cycle(ga, gb);
    drive_a(1, 0, 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_a_gnt", a_gnt, 0);
    chk("t5_ram_ce", ram_ce, 0);
    chk("t5_a_rvalid", a_rvalid, 0);
    chk("t5_a_rdata", a_rdata, 0);
    chk("t5_b_rdata", b_rdata, 0);
    drive_a(0, 0, 0, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(int'(RD_LAT) + 3);

    // Randomized clients that hold requests until granted (occasionally withdrawing).
    pa = 0; pb = 0; awe = 0; bwe = 0; aad = 0; bad = 0; awd = 0; bwd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!pa && $urandom_range(99) < 55) begin
        pa = 1; awe = 1'($urandom_range(1)); aad = $urandom_range(15); awd = $urandom;
      end else if (pa && $urandom_range(99) < 3) begin
        pa = 0;
      end
      if (!pb && $urandom_range(99) < 55) begin
        pb = 1; bwe = 1'($urandom_range(1)); bad = $urandom_range(15); bwd = $urandom;
      end else if (pb && $urandom_range(99) < 3) begin
        pb = 0;
      end
      drive_a(pa, awe, aad, awd);
      drive_b(pb, bwe, bad, bwd);
      run_cycle(ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(int'(RD_LAT) + 2);
    chk("drain_queue_empty", ret_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
